// File: rtl/dm_cache_ctrl_pkg.sv
// Shared definitions for the direct-mapped cache controller: widths, bus
// command encodings common with the bus arbiter, and controller states.
package dm_cache_ctrl_pkg;

    localparam int ADDR_W    = 16;
    localparam int WORDWIDTH = 16;
    localparam int DATA_W    = WORDWIDTH;
    localparam int INDEX_W   = 6;
    localparam int TAG_W     = ADDR_W - INDEX_W;
    localparam int NUM_LINES = 1 << INDEX_W;
    localparam int IOSTATE_W = 2;

    typedef enum logic [IOSTATE_W-1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WT   = 2'd2
    } bus_cmd_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB,
        S_GAP,
        S_FILL,
        S_RESP
    } state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dm_cache_ctrl_cache_line_store.sv
// Tag/data storage for the direct-mapped cache: one combinational read port,
// one synchronous write port, contents undefined after reset.
module cache_line_store
    import dm_cache_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic [INDEX_W-1:0] rd_index,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data
);

    logic [TAG_W-1:0]  tag_mem  [NUM_LINES];
    logic [DATA_W-1:0] data_mem [NUM_LINES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_tag  = tag_mem[rd_index];
    assign rd_data = data_mem[rd_index];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller with one-word
// lines, bridging a CPU core to one requester port of the shared memory bus.
module dm_cache_ctrl
    import dm_cache_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_W-1:0]    cpu_addr,
    input  logic [DATA_W-1:0]    cpu_wdata,
    output logic [DATA_W-1:0]    cpu_rdata,
    output logic                 cpu_ack,
    output logic                 cpu_busy,
    output logic [IOSTATE_W-1:0] bus_rw,
    output logic [ADDR_W-1:0]    bus_addr,
    output logic [DATA_W-1:0]    bus_wdata,
    input  logic [DATA_W-1:0]    bus_rdata,
    input  logic                 bus_rd_en,
    input  logic                 bus_wb_done,
    output logic [15:0]          hit_cnt,
    output logic [15:0]          miss_cnt
);

    state_e                 state_q, state_d;
    bus_cmd_e               bus_rw_q, bus_rw_d;
    logic [ADDR_W-1:0]      bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]      bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   ack_q, ack_d;
    logic                   busy_q, busy_d;
    logic [15:0]            hit_cnt_q, hit_cnt_d;
    logic [15:0]            miss_cnt_q, miss_cnt_d;
    logic [NUM_LINES-1:0]   valid_q, valid_d;
    logic [NUM_LINES-1:0]   dirty_q, dirty_d;
    logic [ADDR_W-1:0]      req_addr_q, req_addr_d;
    logic                   req_we_q, req_we_d;
    logic [DATA_W-1:0]      req_wdata_q, req_wdata_d;

    logic [INDEX_W-1:0]     req_index;
    logic [TAG_W-1:0]       req_tag;
    logic [TAG_W-1:0]       line_tag;
    logic [DATA_W-1:0]      line_data;
    logic                   store_we;
    logic [DATA_W-1:0]      store_wdata;
    logic                   hit;

    assign req_index = req_addr_q[INDEX_W-1:0];
    assign req_tag   = req_addr_q[ADDR_W-1:INDEX_W];
    assign hit       = valid_q[req_index] && (line_tag == req_tag);

    cache_line_store u_store (
        .clk      (clk),
        .rd_index (req_index),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (store_we),
        .wr_index (req_index),
        .wr_tag   (req_tag),
        .wr_data  (store_wdata)
    );

    always_comb begin
        state_d     = state_q;
        bus_rw_d    = bus_rw_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        ack_d       = 1'b0;
        busy_d      = ack_q ? 1'b0 : busy_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        req_addr_d  = req_addr_q;
        req_we_d    = req_we_q;
        req_wdata_d = req_wdata_q;
        store_we    = 1'b0;
        store_wdata = req_wdata_q;

        case (state_q)
            S_IDLE: begin
                // busy stays high through the ack cycle, so no accept until it drops
                if (cpu_req && !busy_q) begin
                    req_addr_d  = cpu_addr;
                    req_we_d    = cpu_we;
                    req_wdata_d = cpu_wdata;
                    busy_d      = 1'b1;
                    state_d     = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    hit_cnt_d = sat_inc(hit_cnt_q);
                    if (req_we_q) begin
                        store_we           = 1'b1;
                        dirty_d[req_index] = 1'b1;
                    end else begin
                        rdata_d = line_data;
                    end
                    state_d = S_RESP;
                end else begin
                    miss_cnt_d = sat_inc(miss_cnt_q);
                    if (valid_q[req_index] && dirty_q[req_index]) begin
                        bus_rw_d    = WT;
                        bus_addr_d  = {line_tag, req_index};
                        bus_wdata_d = line_data;
                        state_d     = S_WB;
                    end else begin
                        bus_rw_d   = RD;
                        bus_addr_d = req_addr_q;
                        state_d    = S_FILL;
                    end
                end
            end
            S_WB: begin
                if (bus_wb_done) begin
                    dirty_d[req_index] = 1'b0;
                    bus_rw_d           = IDLE;
                    state_d            = S_GAP;
                end
            end
            S_GAP: begin
                bus_rw_d   = RD;
                bus_addr_d = req_addr_q;
                state_d    = S_FILL;
            end
            S_FILL: begin
                if (bus_rd_en) begin
                    store_we           = 1'b1;
                    store_wdata        = req_we_q ? req_wdata_q : bus_rdata;
                    valid_d[req_index] = 1'b1;
                    dirty_d[req_index] = req_we_q;
                    if (!req_we_q) begin
                        rdata_d = bus_rdata;
                    end
                    bus_rw_d = IDLE;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                ack_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            bus_rw_q    <= IDLE;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
            req_addr_q  <= '0;
            req_we_q    <= 1'b0;
            req_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            bus_rw_q    <= bus_rw_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            req_addr_q  <= req_addr_d;
            req_we_q    <= req_we_d;
            req_wdata_q <= req_wdata_d;
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_ack   = ack_q;
    assign cpu_busy  = busy_q;
    assign bus_rw    = bus_rw_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

endmodule
